// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the M-extension unit.
// valid_in is taken only while ready is high; valid_out pulses once per finished op.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            valid_in;
  logic [6:0]      opcode;
  logic [2:0]      func3;
  logic [6:0]      func7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            is_muldiv;
  logic            ready;
  logic            busy;
  logic            valid_out;
  logic [XLEN-1:0] result;
  logic [1:0]      dbg_state;

  modport slave (
    input  valid_in, opcode, func3, func7, op_a, op_b, flush,
    output is_muldiv, ready, busy, valid_out, result, dbg_state
  );

  modport master (
    output valid_in, opcode, func3, func7, op_a, op_b, flush,
    input  is_muldiv, ready, busy, valid_out, result, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply-divide unit: single-cycle or shift-add multiply, restoring divide.
// Handshake: an op is accepted when valid_in && is_muldiv && ready && !flush on a rising edge.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_func3;
  logic              r_neg_q, r_neg_r;
  logic [2*XLEN-1:0] r_acc, r_opx;
  logic [XLEN-1:0]   r_opy, r_result;

  logic              w_ready, w_busy, w_valid_out;
  logic              w_is_m, w_accept, w_is_mul, w_last;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_spec_res;
  logic              w_div_zero, w_div_ovf, w_div_special;
  logic [2*XLEN-1:0] w_fast_prod, w_mul_acc;
  logic [XLEN:0]     w_shift, w_sub;
  logic              w_fits;
  logic [XLEN-1:0]   w_rem_n, w_quo_n, w_div_res;

  function automatic logic [XLEN-1:0] fix_mul(input logic [2*XLEN-1:0] p,
                                               input logic neg, input logic [2:0] f3);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f3 == 3'b000) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  assign w_is_m   = (bus.opcode == 7'b0110011) && (bus.func7 == 7'b0000001);
  assign w_accept = bus.valid_in && w_is_m && w_ready && !bus.flush;
  assign w_is_mul = !bus.func3[2];

  // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
  assign w_a_sgn = w_is_mul ? (bus.func3 == 3'b001 || bus.func3 == 3'b010) : !bus.func3[0];
  assign w_b_sgn = w_is_mul ? (bus.func3 == 3'b001) : !bus.func3[0];
  assign w_a_neg = w_a_sgn && bus.op_a[XLEN-1];
  assign w_b_neg = w_b_sgn && bus.op_b[XLEN-1];
  assign w_a_mag = w_a_neg ? -bus.op_a : bus.op_a;
  assign w_b_mag = w_b_neg ? -bus.op_b : bus.op_b;

  assign w_div_zero    = (bus.op_b == '0);
  assign w_div_ovf     = !bus.func3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  assign w_div_special = w_div_zero || w_div_ovf;
  assign w_spec_res    = w_div_zero ? (bus.func3[1] ? bus.op_a : '1)
                                    : (bus.func3[1] ? '0 : bus.op_a);

  assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
  assign w_mul_acc   = r_acc + (r_opy[0] ? r_opx : '0);

  // Divide: r_acc low half holds the partial remainder, r_opy shifts dividend out / quotient in.
  assign w_shift   = {r_acc[XLEN-1:0], r_opy[XLEN-1]};
  assign w_sub     = w_shift - {1'b0, r_opx[XLEN-1:0]};
  assign w_fits    = !w_sub[XLEN];
  assign w_rem_n   = w_fits ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_n   = {r_opy[XLEN-2:0], w_fits};
  assign w_div_res = r_func3[1] ? (r_neg_r ? -w_rem_n : w_rem_n)
                                : (r_neg_q ? -w_quo_n : w_quo_n);
  assign w_last    = (r_cnt == CW'(XLEN-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (w_accept) begin
          if (w_is_mul) w_next = FAST_MUL ? S_DONE : S_MUL;
          else          w_next = w_div_special ? S_DONE : S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (bus.flush)   w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_valid_out = 1'b0;
    case (r_state)
      S_IDLE:       w_ready = 1'b1;
      S_DONE:       begin w_ready = 1'b1; w_valid_out = 1'b1; end
      S_MUL, S_DIV: w_busy = 1'b1;
      default:      w_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_func3  <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc    <= '0;
      r_opx    <= '0;
      r_opy    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_func3 <= bus.func3;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_cnt   <= '0;
      r_acc   <= '0;
      if (w_is_mul) begin
        r_opx <= {{XLEN{1'b0}}, w_a_mag};
        r_opy <= w_b_mag;
        if (FAST_MUL) r_result <= fix_mul(w_fast_prod, w_a_neg ^ w_b_neg, bus.func3);
      end else begin
        r_opx <= {{XLEN{1'b0}}, w_b_mag};
        r_opy <= w_a_mag;
        if (w_div_special) r_result <= w_spec_res;
      end
    end else if (!bus.flush && r_state == S_MUL) begin
      r_acc <= w_mul_acc;
      r_opx <= r_opx << 1;
      r_opy <= r_opy >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= fix_mul(w_mul_acc, r_neg_q, r_func3);
    end else if (!bus.flush && r_state == S_DIV) begin
      r_acc <= {{XLEN{1'b0}}, w_rem_n};
      r_opy <= w_quo_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_div_res;
    end
  end

  assign bus.is_muldiv = w_is_m;
  assign bus.ready     = w_ready;
  assign bus.busy      = w_busy;
  assign bus.valid_out = w_valid_out;
  assign bus.result    = r_result;
  assign bus.dbg_state = r_state;
endmodule
